// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master port between NREQ requesters.
// Sequences IDLE/SETUP/ACCESS with pready wait states and an ACCESS timeout.
module apb_req_arbiter #(
  parameter int ADDR    = 10,
  parameter int DATA    = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*ADDR-1:0] req_addr,
  input  logic [NREQ*DATA-1:0] req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [DATA-1:0]      rdata,
  output logic                 err,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [ADDR-1:0]      paddr,
  output logic [DATA-1:0]      pwdata,
  input  logic [DATA-1:0]      prdata,
  input  logic                 pready,
  input  logic                 pslverr
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IDXW-1:0] LAST_RST = IDXW'(NREQ - 1);
  localparam logic [IDXW:0]   NREQ_W   = (IDXW + 1)'(NREQ);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [IDXW-1:0] last;
  logic [IDXW-1:0] winner;
  logic [IDXW:0]   cand;
  logic            found;
  logic [CNTW-1:0] cnt;
  logic            any_req;
  logic            timeout_hit;
  logic            xfer_end;

  logic [NREQ-1:0] gnt_d;
  logic [NREQ-1:0] done_d;
  logic [DATA-1:0] rdata_d;
  logic            err_d;
  logic            psel_d;
  logic            penable_d;
  logic            pwrite_d;
  logic [ADDR-1:0] paddr_d;
  logic [DATA-1:0] pwdata_d;

  // Requester handshake: a requester holds req and its command fields stable
  // until it sees its one-cycle gnt pulse; the command is latched on that edge
  // and the requester may then drop req or change fields. Dropping req before
  // gnt withdraws the request with no side effects. done marks completion.
  assign any_req     = |req;
  assign timeout_hit = (cnt == CNT_LAST);
  assign xfer_end    = (state == ST_ACCESS) && (pready || timeout_hit);

  // Round-robin search starting just after the previous winner.
  always_comb begin
    winner = last;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last} + (IDXW + 1)'(k);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!found && req[cand[IDXW-1:0]]) begin
        winner = cand[IDXW-1:0];
        found  = 1'b1;
      end
    end
  end

  // State register, winner pointer and wait-state counter.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= ST_IDLE;
      last  <= LAST_RST;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && any_req) begin
        last <= winner;
      end
      if (state == ST_SETUP) begin
        cnt <= '0;
      end else if (state == ST_ACCESS && !pready && !timeout_hit) begin
        cnt <= cnt + CNTW'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (any_req) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: if (xfer_end) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; anything not touched holds.
  always_comb begin
    gnt_d     = '0;
    done_d    = '0;
    rdata_d   = rdata;
    err_d     = err;
    psel_d    = psel;
    penable_d = penable;
    pwrite_d  = pwrite;
    paddr_d   = paddr;
    pwdata_d  = pwdata;
    case (state)
      ST_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        pwrite_d  = 1'b0;
        paddr_d   = '0;
        pwdata_d  = '0;
        if (any_req) begin
          psel_d         = 1'b1;
          pwrite_d       = req_write[winner];
          paddr_d        = req_addr[winner*ADDR +: ADDR];
          pwdata_d       = req_wdata[winner*DATA +: DATA];
          gnt_d[winner]  = 1'b1;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (xfer_end) begin
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          pwrite_d     = 1'b0;
          paddr_d      = '0;
          pwdata_d     = '0;
          done_d[last] = 1'b1;
          // A timeout reports an error and never updates read data.
          err_d        = pready ? pslverr : 1'b1;
          if (pready && !pwrite) begin
            rdata_d = prdata;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      gnt     <= '0;
      done    <= '0;
      rdata   <= '0;
      err     <= 1'b0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else begin
      gnt     <= gnt_d;
      done    <= done_d;
      rdata   <= rdata_d;
      err     <= err_d;
      psel    <= psel_d;
      penable <= penable_d;
      pwrite  <= pwrite_d;
      paddr   <= paddr_d;
      pwdata  <= pwdata_d;
    end
  end

  a_gnt_onehot: assert property (@(posedge pclk) disable iff (preset) $onehot0(gnt))
    else $error("gnt asserted for more than one requester");
  a_done_onehot: assert property (@(posedge pclk) disable iff (preset) $onehot0(done))
    else $error("done asserted for more than one requester");
  a_penable_psel: assert property (@(posedge pclk) disable iff (preset) penable |-> psel)
    else $error("penable without psel");

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomized self-checking bench for apb_req_arbiter against a
// transaction-level round-robin / APB timing model.
module tb_apb_req_arbiter;

  localparam int ADDR    = 10;
  localparam int DATA    = 8;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic                 pclk = 1'b0;
  logic                 preset;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_write;
  logic [NREQ*ADDR-1:0] req_addr;
  logic [NREQ*DATA-1:0] req_wdata;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic [DATA-1:0]      rdata;
  logic                 err;
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [ADDR-1:0]      paddr;
  logic [DATA-1:0]      pwdata;
  logic [DATA-1:0]      prdata;
  logic                 pready;
  logic                 pslverr;

  int checks = 0;
  int errors = 0;

  // Reference model state: last winner, visible rdata/err.
  int              m_last;
  logic [DATA-1:0] m_rdata;
  logic            m_err;
  logic [DATA-1:0] exp_q[$];

  apb_req_arbiter #(
    .ADDR(ADDR), .DATA(DATA), .NREQ(NREQ), .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk(pclk), .preset(preset), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .rdata(rdata), .err(err), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  // ---------------- clock / reset ----------------
  always #5 pclk = ~pclk;

  task automatic model_reset();
    m_last  = NREQ - 1;
    m_rdata = '0;
    m_err   = 1'b0;
    exp_q.delete();
  endtask

  task automatic apply_reset();
    preset  = 1'b1;
    req     = '0;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    repeat (2) @(posedge pclk);
    #1;
    preset = 1'b0;
    model_reset();
  endtask

  // ---------------- model ----------------
  function automatic int rr_pick(input int last, input int mask);
    for (int k = 1; k <= NREQ; k++) begin
      if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // ---------------- drivers ----------------
  task automatic set_cmd(input int i, input logic w, input logic [ADDR-1:0] a,
                         input logic [DATA-1:0] d);
    req_write[i]             = w;
    req_addr[i*ADDR +: ADDR] = a;
    req_wdata[i*DATA +: DATA] = d;
  endtask

  task automatic randomize_cmds();
    for (int i = 0; i < NREQ; i++) begin
      set_cmd(i, 1'($urandom_range(0, 1)), ADDR'($urandom), DATA'($urandom));
    end
  endtask

  // One complete transfer: the slave inserts 'waits' pready-low ACCESS cycles.
  task automatic xfer(input int mask, input int waits, input logic slverr,
                      input logic [DATA-1:0] rd, input bit hold_others);
    int              w;
    int              nwait;
    int              rem;
    logic            timed_out;
    logic [ADDR-1:0] a;
    logic [DATA-1:0] d;
    logic            wr;
    logic [NREQ-1:0] oh;
    logic [DATA-1:0] exp_rd;

    w  = rr_pick(m_last, mask);
    a  = req_addr[w*ADDR +: ADDR];
    d  = req_wdata[w*DATA +: DATA];
    wr = req_write[w];
    oh = '0;
    oh[w] = 1'b1;
    req    = NREQ'(mask);
    pready = 1'b0;

    @(posedge pclk); #1;
    checks++;
    if (gnt !== oh || done !== '0 || psel !== 1'b1 || penable !== 1'b0 ||
        paddr !== a || pwrite !== wr || pwdata !== d) begin
      errors++;
      $display("FAIL grant: gnt=%b done=%b psel=%b penable=%b paddr=%h pwrite=%b pwdata=%h; need gnt=%b done=0 psel=1 penable=0 paddr=%h pwrite=%b pwdata=%h",
               gnt, done, psel, penable, paddr, pwrite, pwdata, oh, a, wr, d);
    end

    timed_out = (waits >= TIMEOUT);
    nwait     = timed_out ? TIMEOUT - 1 : waits;
    exp_rd    = (!timed_out && !wr) ? rd : m_rdata;
    exp_q.push_back(exp_rd);
    m_last  = w;
    m_rdata = exp_rd;
    m_err   = timed_out ? 1'b1 : slverr;

    rem = mask & ~(1 << w);
    req = hold_others ? NREQ'(rem) : '0;
    // Fields may change once granted; the latched command must not follow.
    set_cmd(w, 1'($urandom_range(0, 1)), ADDR'($urandom), DATA'($urandom));
    pready  = 1'($urandom_range(0, 1));
    pslverr = 1'($urandom_range(0, 1));
    prdata  = DATA'($urandom);

    @(posedge pclk); #1;
    checks++;
    if (gnt !== '0 || psel !== 1'b1 || penable !== 1'b1 || paddr !== a ||
        pwrite !== wr || pwdata !== d || done !== '0) begin
      errors++;
      $display("FAIL setup: gnt=%b psel=%b penable=%b paddr=%h pwrite=%b pwdata=%h done=%b; need gnt=0 psel=1 penable=1 paddr=%h pwrite=%b pwdata=%h done=0",
               gnt, psel, penable, paddr, pwrite, pwdata, done, a, wr, d);
    end

    for (int i = 0; i <= nwait; i++) begin
      pready  = (i == waits);
      pslverr = (i == waits) ? slverr : 1'($urandom_range(0, 1));
      prdata  = (i == waits) ? rd : DATA'($urandom);
      @(posedge pclk); #1;
      checks++;
      if (i < nwait) begin
        if (done !== '0 || psel !== 1'b1 || penable !== 1'b1 || paddr !== a ||
            pwrite !== wr || pwdata !== d) begin
          errors++;
          $display("FAIL wait%0d: done=%b psel=%b penable=%b paddr=%h pwrite=%b pwdata=%h; need done=0 psel=1 penable=1 paddr=%h pwrite=%b pwdata=%h",
                   i, done, psel, penable, paddr, pwrite, pwdata, a, wr, d);
        end
      end else begin
        exp_rd = exp_q.pop_front();
        if (done !== oh || err !== m_err || rdata !== exp_rd || psel !== 1'b0 ||
            penable !== 1'b0 || paddr !== '0 || pwdata !== '0 || pwrite !== 1'b0 ||
            gnt !== '0) begin
          errors++;
          $display("FAIL done: done=%b err=%b rdata=%h psel=%b penable=%b paddr=%h pwdata=%h pwrite=%b gnt=%b; need done=%b err=%b rdata=%h rest 0",
                   done, err, rdata, psel, penable, paddr, pwdata, pwrite, gnt, oh, m_err, exp_rd);
        end
      end
    end
    pready  = 1'b0;
    pslverr = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    req = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge pclk); #1;
      checks++;
      if (gnt !== '0 || done !== '0 || psel !== 1'b0 || penable !== 1'b0 ||
          err !== m_err || rdata !== m_rdata) begin
        errors++;
        $display("FAIL idle: gnt=%b done=%b psel=%b penable=%b err=%b rdata=%h; need 0 0 0 0 err=%b rdata=%h",
                 gnt, done, psel, penable, err, rdata, m_err, m_rdata);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    preset    = 1'b1;
    req       = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    prdata    = '0;
    @(posedge pclk); #1;
    checks++;
    if (gnt !== '0 || done !== '0 || rdata !== '0 || err !== 1'b0 || psel !== 1'b0 ||
        penable !== 1'b0 || pwrite !== 1'b0 || paddr !== '0 || pwdata !== '0) begin
      errors++;
      $display("FAIL reset: gnt=%b done=%b rdata=%h err=%b psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h; need all 0",
               gnt, done, rdata, err, psel, penable, pwrite, paddr, pwdata);
    end
    apply_reset();
    idle_cycles(3);
  endtask

  task automatic test_single_read();
    apply_reset();
    randomize_cmds();
    set_cmd(2, 1'b0, 10'h0A5, 8'h00);
    xfer(4'b0100, 0, 1'b0, 8'h3C, 1'b0);
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    randomize_cmds();
    xfer(4'b1111, 0, 1'b0, DATA'($urandom), 1'b1);
    xfer(4'b1110, 0, 1'b0, DATA'($urandom), 1'b1);
    xfer(4'b1100, 0, 1'b0, DATA'($urandom), 1'b1);
    xfer(4'b1000, 0, 1'b0, DATA'($urandom), 1'b0);
    idle_cycles(2);
  endtask

  task automatic test_wait_write();
    set_cmd(1, 1'b1, 10'h3FF, 8'hA5);
    xfer(4'b0010, 3, 1'b0, DATA'($urandom), 1'b0);
  endtask

  task automatic test_timeout();
    randomize_cmds();
    set_cmd(3, 1'b0, ADDR'($urandom), '0);
    xfer(4'b1000, TIMEOUT + 24, 1'b0, DATA'($urandom), 1'b0);
    randomize_cmds();
    xfer(4'b1111, 0, 1'b0, DATA'($urandom), 1'b0);
    // Last wait cycle before the timeout still completes normally.
    set_cmd(1, 1'b0, ADDR'($urandom), '0);
    xfer(4'b0010, TIMEOUT - 1, 1'b0, DATA'($urandom), 1'b0);
    set_cmd(2, 1'b0, ADDR'($urandom), '0);
    xfer(4'b0100, TIMEOUT, 1'b0, DATA'($urandom), 1'b0);
  endtask

  task automatic test_slverr();
    set_cmd(0, 1'b0, ADDR'($urandom), '0);
    xfer(4'b0001, 1, 1'b1, 8'h5A, 1'b0);
    set_cmd(1, 1'b1, ADDR'($urandom), DATA'($urandom));
    xfer(4'b0010, 0, 1'b0, DATA'($urandom), 1'b0);
  endtask

  task automatic test_reset_mid();
    randomize_cmds();
    set_cmd(2, 1'b0, ADDR'($urandom), '0);
    req    = 4'b0100;
    pready = 1'b0;
    @(posedge pclk); #1;
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL mid_grant: gnt=%b; need 0100", gnt);
    end
    req = '0;
    repeat (3) @(posedge pclk);
    #1;
    preset = 1'b1;
    @(posedge pclk); #1;
    checks++;
    if (gnt !== '0 || done !== '0 || rdata !== '0 || err !== 1'b0 || psel !== 1'b0 ||
        penable !== 1'b0 || pwrite !== 1'b0 || paddr !== '0 || pwdata !== '0) begin
      errors++;
      $display("FAIL mid_reset: gnt=%b done=%b rdata=%h err=%b psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h; need all 0",
               gnt, done, rdata, err, psel, penable, pwrite, paddr, pwdata);
    end
    preset = 1'b0;
    model_reset();
    randomize_cmds();
    xfer(4'b1111, 0, 1'b0, DATA'($urandom), 1'b0);
  endtask

  task automatic test_random();
    int mask;
    int waits;
    for (int n = 0; n < 80; n++) begin
      randomize_cmds();
      mask  = $urandom_range(1, (1 << NREQ) - 1);
      waits = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 1)
                                          : $urandom_range(0, 3);
      xfer(mask, waits, 1'($urandom_range(0, 3) == 0), DATA'($urandom),
           1'($urandom_range(0, 1)));
      idle_cycles($urandom_range(0, 2));
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_read();
    test_wait_write();
    test_back_to_back();
    test_timeout();
    test_slverr();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
